wasm_global_file: RTL and testbench
===================================

WASM_GLOBAL_FILE -- requirements
Module: wasm_global_file

Interface
REQ-001 Parameter NUM_GLOBALS, default 256, number of global slots (power of two, 2..1024).
REQ-002 Parameter NUM_RD, default 2, number of independent read ports.
REQ-003 Parameter IDX_W, default $clog2(NUM_GLOBALS), index width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 clear  in  1  one-cycle request to wipe all globals and restart loading.
REQ-007 init_valid  in  1  init stream beat valid.
REQ-008 init_ready  out  1  init stream beat accepted when init_valid && init_ready.
REQ-009 init_data  in  global_entry_t  {vtype, value, mutable_flag} for next sequential slot.
REQ-010 init_last  in  1  marks final init beat.
REQ-011 rd_en  in  NUM_RD  per-port read request.
REQ-012 rd_idx  in  NUM_RD x IDX_W  per-port read index.
REQ-013 rd_data  out  NUM_RD x stack_entry_t  per-port read result.
REQ-014 rd_valid  out  NUM_RD  per-port read-data valid pulse.
REQ-015 rd_oob  out  NUM_RD  per-port out-of-range read pulse.
REQ-016 wr_en / wr_idx / wr_data  in  1 / IDX_W / stack_entry_t  runtime global.set.
REQ-017 wr_done / wr_error / wr_oob  out  1 each  write success / immutable target / out-of-range pulses.
REQ-018 ready  out  1  high only in RUN state.
REQ-019 num_globals  out  IDX_W+1  count of loaded globals.

Function
REQ-020 FSM states CLEAR, LOAD, RUN; reset enters CLEAR.
REQ-021 CLEAR writes all-zero to slot sweep_ptr each cycle, sweep_ptr 0..NUM_GLOBALS-1, then LOAD; takes exactly NUM_GLOBALS cycles; num_globals=0 throughout.
REQ-022 LOAD: init_ready=1 while num_globals<NUM_GLOBALS; each accepted beat writes slot num_globals and increments it.
REQ-023 LOAD exits to RUN on cycle after accepted beat with init_last=1, or after beat filling slot NUM_GLOBALS-1 (init_last ignored); init_ready=0 outside LOAD.
REQ-024 clear in LOAD or RUN: next state CLEAR, sweep_ptr=0, num_globals=0; clear during CLEAR restarts sweep at 0; clear wins over same-cycle init beat or write.
REQ-025 Reads: 1-cycle latency; rd_en in RUN with rd_idx<num_globals -> next cycle rd_valid=1, rd_data={vtype,value} of slot.
REQ-026 Read with rd_idx>=num_globals in RUN -> next cycle rd_oob=1, rd_valid=0, rd_data=0.
REQ-027 Read/write requests outside RUN ignored: all response pulses 0, storage unchanged.
REQ-028 Write in RUN, wr_idx>=num_globals -> next cycle wr_oob=1, no update.
REQ-029 Write to slot with mutable_flag=0 -> next cycle wr_error=1, no update.
REQ-030 Otherwise value <= wr_data.value, vtype and mutable_flag unchanged, next cycle wr_done=1; wr_data.vtype not checked.
REQ-031 Same-cycle successful write and read of same index: read returns new value (write-first forwarding), independently per port.
REQ-032 All rd_*/wr_* responses are single-cycle pulses, zero when no request in prior cycle.
REQ-033 Any number of ports may read same index in same cycle.

Reset
REQ-034 rst_n low asynchronously: state=CLEAR, sweep_ptr=0, num_globals=0, init_ready=0, ready=0, all rd_*/wr_* outputs 0.
REQ-035 Storage array not reset directly; zeroed by CLEAR sweep after reset release.
REQ-036 Reset mid-LOAD or mid-sweep discards progress; loading restarts from slot 0 after sweep.

Structure
REQ-037 stack_entry_t, global_entry_t and new enum global_file_state_e (CLEAR, LOAD, RUN) reside in wasm_pkg.
REQ-038 Storage in sub-module wasm_global_bank: one synchronous write port, NUM_RD synchronous read ports, no reset, RAM-inferable.
REQ-039 Range, mutability, forwarding and FSM logic reside in wasm_global_file.

Verification
REQ-040 Reset release -> ready=0 for 256 cycles, then init_ready=1; 3 beats, last with init_last -> num_globals=3, ready=1 next cycle.
REQ-041 Slot1 mutable i32 5; wr_idx=1 value 9 with port0 rd_idx=1 same cycle -> wr_done=1, rd_data.value=9 next cycle.
REQ-042 Slot0 immutable value 7; write 0 value 1 -> wr_error=1, later read returns 7.
REQ-043 num_globals=3; rd_idx=3 port1, wr_idx=200 -> rd_oob[1]=1, wr_oob=1, rd_valid[1]=0.
REQ-044 Stream 256 beats with init_last=0 -> RUN after beat 256, num_globals=256, init_ready=0.
REQ-045 clear in RUN, or rst_n low mid-LOAD -> num_globals=0, reads of slot 0 after reload of 1 zero-valued beat return 0, not prior contents.

Source files
------------

// File: rtl/wasm_pkg.sv
// Shared WebAssembly core types.
// Global file entries, stack entries and global file FSM states.
package wasm_pkg;

   typedef enum logic [1:0] {
      VT_I32 = 2'd0,
      VT_I64 = 2'd1,
      VT_F32 = 2'd2,
      VT_F64 = 2'd3
   } val_type_e;

   typedef struct packed {
      val_type_e   vtype;
      logic [63:0] value;
   } stack_entry_t;

   typedef struct packed {
      val_type_e   vtype;
      logic [63:0] value;
      logic        mutable_flag;
   } global_entry_t;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } global_file_state_e;

endpackage

// File: rtl/wasm_global_file_if.sv
// Bus bundle of the global file: init stream,
// read ports, global.set port and status.
interface wasm_global_file_if #(
   parameter int NUM_GLOBALS = 256,
   parameter int NUM_RD      = 2,
   parameter int IDX_W       = $clog2(NUM_GLOBALS)
);
   import wasm_pkg::*;

   logic                           clear;
   logic                           init_valid;
   logic                           init_ready;
   global_entry_t                  init_data;
   logic                           init_last;
   logic [NUM_RD-1:0]              rd_en;
   logic [NUM_RD-1:0][IDX_W-1:0]   rd_idx;
   stack_entry_t [NUM_RD-1:0]      rd_data;
   logic [NUM_RD-1:0]              rd_valid;
   logic [NUM_RD-1:0]              rd_oob;
   logic                           wr_en;
   logic [IDX_W-1:0]               wr_idx;
   stack_entry_t                   wr_data;
   logic                           wr_done;
   logic                           wr_error;
   logic                           wr_oob;
   logic                           ready;
   logic [IDX_W:0]                 num_globals;

   modport master (
      output clear, init_valid, init_data, init_last,
      output rd_en, rd_idx, wr_en, wr_idx, wr_data,
      input  init_ready, rd_data, rd_valid, rd_oob,
      input  wr_done, wr_error, wr_oob, ready, num_globals
   );

   modport slave (
      input  clear, init_valid, init_data, init_last,
      input  rd_en, rd_idx, wr_en, wr_idx, wr_data,
      output init_ready, rd_data, rd_valid, rd_oob,
      output wr_done, wr_error, wr_oob, ready, num_globals
   );

endinterface

// File: rtl/wasm_global_bank.sv
// Global storage: one write port with separate type/value
// enables, NUM_RD read-first synchronous read ports, no reset.
module wasm_global_bank
   import wasm_pkg::*;
#(
   parameter int NUM_GLOBALS = 256,
   parameter int NUM_RD      = 2,
   parameter int IDX_W       = $clog2(NUM_GLOBALS)
) (
   input  logic                         clk,
   input  logic                         we_meta_i,
   input  logic                         we_val_i,
   input  logic [IDX_W-1:0]             waddr_i,
   input  stack_entry_t                 wdata_i,
   input  logic [NUM_RD-1:0]            re_i,
   input  logic [NUM_RD-1:0][IDX_W-1:0] raddr_i,
   output stack_entry_t [NUM_RD-1:0]    rdata_o
);

   val_type_e                 meta_mem [NUM_GLOBALS];
   logic [63:0]               val_mem  [NUM_GLOBALS];
   stack_entry_t [NUM_RD-1:0] rdata_q;

   // Write type/value fields independently; reads see old contents.
   always_ff @(posedge clk) begin
      if (we_meta_i) meta_mem[waddr_i] <= wdata_i.vtype;
      if (we_val_i)  val_mem[waddr_i]  <= wdata_i.value;
      for (int p = 0; p < NUM_RD; p++) begin
         if (re_i[p]) begin
            rdata_q[p].vtype <= meta_mem[raddr_i[p]];
            rdata_q[p].value <= val_mem[raddr_i[p]];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wasm_global_file.sv
// WebAssembly global file: clear sweep, sequential init load,
// then range/mutability-checked reads and global.set writes.
module wasm_global_file
   import wasm_pkg::*;
#(
   parameter int NUM_GLOBALS = 256,
   parameter int NUM_RD      = 2,
   parameter int IDX_W       = $clog2(NUM_GLOBALS)
) (
   input  logic              clk,
   input  logic              rst_n,
   wasm_global_file_if.slave bus
);

   localparam int CW = IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GLOBALS - 1);
   localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_GLOBALS - 1);
   localparam logic [CW-1:0]    FULL_CNT = CW'(NUM_GLOBALS);

   global_file_state_e        state_q;
   logic [IDX_W-1:0]          sweep_q;
   logic [CW-1:0]             cnt_q;
   logic [NUM_GLOBALS-1:0]    mut_q;

   logic [NUM_RD-1:0]         rd_valid_q;
   logic [NUM_RD-1:0]         rd_oob_q;
   logic [NUM_RD-1:0]         fwd_q;
   logic [63:0]               fwd_val_q;
   logic                      wr_done_q;
   logic                      wr_error_q;
   logic                      wr_oob_q;

   logic                      run_act;
   logic                      beat;
   logic                      wr_in;
   logic                      wr_ok;
   logic [NUM_RD-1:0]         rd_req;
   logic [NUM_RD-1:0]         rd_in;

   logic                      b_we_meta;
   logic                      b_we_val;
   logic [IDX_W-1:0]          b_waddr;
   stack_entry_t              b_wdata;
   stack_entry_t [NUM_RD-1:0] b_rdata;
   stack_entry_t [NUM_RD-1:0] rd_resp;

   logic                      unused_vtype;

   assign unused_vtype = ^bus.wr_data.vtype;

   assign run_act = (state_q == RUN) && !bus.clear;
   assign beat    = (state_q == LOAD) && bus.init_valid
                 && bus.init_ready && !bus.clear;
   assign wr_in   = run_act && bus.wr_en
                 && ({1'b0, bus.wr_idx} < cnt_q);
   assign wr_ok   = wr_in && mut_q[bus.wr_idx];

   // Per-port request qualification against the loaded count.
   always_comb begin
      rd_req = '0;
      rd_in  = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_req[p] = run_act && bus.rd_en[p];
         rd_in[p]  = {1'b0, bus.rd_idx[p]} < cnt_q;
      end
   end

   // Select the single bank write: sweep, init beat or global.set.
   always_comb begin
      b_we_meta = 1'b0;
      b_we_val  = 1'b0;
      b_waddr   = '0;
      b_wdata   = '0;
      if (state_q == CLEAR) begin
         b_we_meta = 1'b1;
         b_we_val  = 1'b1;
         b_waddr   = sweep_q;
      end else if (beat) begin
         b_we_meta     = 1'b1;
         b_we_val      = 1'b1;
         b_waddr       = cnt_q[IDX_W-1:0];
         b_wdata.vtype = bus.init_data.vtype;
         b_wdata.value = bus.init_data.value;
      end else if (wr_ok) begin
         b_we_val      = 1'b1;
         b_waddr       = bus.wr_idx;
         b_wdata.value = bus.wr_data.value;
      end
   end

   wasm_global_bank #(
      .NUM_GLOBALS (NUM_GLOBALS),
      .NUM_RD      (NUM_RD),
      .IDX_W       (IDX_W)
   ) u_bank (
      .clk       (clk),
      .we_meta_i (b_we_meta),
      .we_val_i  (b_we_val),
      .waddr_i   (b_waddr),
      .wdata_i   (b_wdata),
      .re_i      (rd_req),
      .raddr_i   (bus.rd_idx),
      .rdata_o   (b_rdata)
   );

   // Sequencer: sweep every slot, load the init stream, then run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         sweep_q <= '0;
         cnt_q   <= '0;
      end else if (bus.clear) begin
         state_q <= CLEAR;
         sweep_q <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            CLEAR: begin
               if (sweep_q == LAST_IDX) begin
                  state_q <= LOAD;
                  sweep_q <= '0;
               end else begin
                  sweep_q <= sweep_q + IDX_W'(1);
               end
            end
            LOAD: begin
               if (beat) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (bus.init_last || cnt_q == LAST_CNT)
                     state_q <= RUN;
               end
            end
            RUN: state_q <= RUN;
            default: state_q <= CLEAR;
         endcase
      end
   end

   // Mutability flags shadow the bank so global.set resolves in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mut_q <= '0;
      end else if (state_q == CLEAR) begin
         mut_q[sweep_q] <= 1'b0;
      end else if (beat) begin
         mut_q[cnt_q[IDX_W-1:0]] <= bus.init_data.mutable_flag;
      end
   end

   // Registered response pulses and write-first forwarding tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= '0;
         rd_oob_q   <= '0;
         fwd_q      <= '0;
         fwd_val_q  <= '0;
         wr_done_q  <= 1'b0;
         wr_error_q <= 1'b0;
         wr_oob_q   <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_RD; p++) begin
            rd_valid_q[p] <= rd_req[p] && rd_in[p];
            rd_oob_q[p]   <= rd_req[p] && !rd_in[p];
            fwd_q[p]      <= rd_req[p] && rd_in[p] && wr_ok
                          && (bus.rd_idx[p] == bus.wr_idx);
         end
         if (wr_ok) fwd_val_q <= bus.wr_data.value;
         wr_done_q  <= wr_ok;
         wr_error_q <= wr_in && !mut_q[bus.wr_idx];
         wr_oob_q   <= run_act && bus.wr_en && !wr_in;
      end
   end

   // Read data is zero unless valid; forwarded value overrides bank.
   always_comb begin
      rd_resp = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (rd_valid_q[p]) begin
            rd_resp[p] = b_rdata[p];
            if (fwd_q[p]) rd_resp[p].value = fwd_val_q;
         end
      end
   end

   assign bus.init_ready  = (state_q == LOAD) && (cnt_q < FULL_CNT);
   assign bus.ready       = (state_q == RUN);
   assign bus.num_globals = cnt_q;
   assign bus.rd_data     = rd_resp;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_oob      = rd_oob_q;
   assign bus.wr_done     = wr_done_q;
   assign bus.wr_error    = wr_error_q;
   assign bus.wr_oob      = wr_oob_q;

endmodule

// File: tb/tb_wasm_global_file.sv
// Bench for wasm_global_file: directed scenarios plus
// randomized traffic against an array-based model.
module tb_wasm_global_file;
   import wasm_pkg::*;

   localparam int NG  = 256;
   localparam int NRD = 2;
   localparam int IW  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [1:0]  m_vt  [NG];
   logic [63:0] m_val [NG];
   bit          m_mut [NG];
   int          m_n;

   wasm_global_file_if bus_if ();

   wasm_global_file dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus_if.clear      = 1'b0;
      bus_if.init_valid = 1'b0;
      bus_if.init_data  = '0;
      bus_if.init_last  = 1'b0;
      bus_if.rd_en      = '0;
      bus_if.rd_idx     = '0;
      bus_if.wr_en      = 1'b0;
      bus_if.wr_idx     = '0;
      bus_if.wr_data    = '0;
   endtask

   task automatic model_wipe;
      for (int i = 0; i < NG; i++) begin
         m_vt[i]  = 2'd0;
         m_val[i] = 64'd0;
         m_mut[i] = 1'b0;
      end
      m_n = 0;
   endtask

   task automatic wait_load(input bit junk, output int cyc);
      logic [6:0] resp;
      cyc = 0;
      while (bus_if.init_ready !== 1'b1 && cyc < 2000) begin
         if (junk) begin
            bus_if.rd_en         = '1;
            bus_if.rd_idx        = '0;
            bus_if.wr_en         = 1'b1;
            bus_if.wr_idx        = '0;
            bus_if.wr_data.value = {$urandom, $urandom};
         end
         tick;
         cyc++;
         if (junk) begin
            resp = {bus_if.ready, bus_if.rd_valid, bus_if.rd_oob,
                    bus_if.wr_done, bus_if.wr_error, bus_if.wr_oob};
            resp[6] = resp[6] & (bus_if.init_ready !== 1'b1);
            n_cmp++;
            if (resp !== 7'd0) begin
               n_err++;
               $display("FAIL not_run_resp cyc %0d: got %b required 0",
                        cyc, resp);
            end
         end
      end
      idle;
   endtask

   task automatic load_beat(input logic [1:0] vt, input logic [63:0] val,
                            input bit mut, input bit last);
      bus_if.init_valid             = 1'b1;
      bus_if.init_data.vtype        = val_type_e'(vt);
      bus_if.init_data.value        = val;
      bus_if.init_data.mutable_flag = mut;
      bus_if.init_last              = last;
      n_cmp++;
      if (bus_if.init_ready !== 1'b1) begin
         n_err++;
         $display("FAIL init_ready beat %0d: got %b required 1",
                  m_n, bus_if.init_ready);
      end
      tick;
      m_vt[m_n]  = vt;
      m_val[m_n] = val;
      m_mut[m_n] = mut;
      m_n++;
      bus_if.init_valid = 1'b0;
      bus_if.init_last  = 1'b0;
   endtask

   task automatic test_reset;
      int cyc;
      idle;
      model_wipe;
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({bus_if.ready, bus_if.init_ready, bus_if.num_globals} !== '0) begin
         n_err++;
         $display("FAIL reset_status: got rdy=%b irdy=%b n=%0d required 0",
                  bus_if.ready, bus_if.init_ready, bus_if.num_globals);
      end
      n_cmp++;
      if ({bus_if.rd_valid, bus_if.rd_oob, bus_if.rd_data,
           bus_if.wr_done, bus_if.wr_error, bus_if.wr_oob} !== '0) begin
         n_err++;
         $display("FAIL reset_resp: got v=%b o=%b required 0",
                  bus_if.rd_valid, bus_if.rd_oob);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_load(1'b1, cyc);
      n_cmp++;
      if (cyc !== 256) begin
         n_err++;
         $display("FAIL sweep_len: got %0d cycles required 256", cyc);
      end
   endtask

   task automatic test_load3;
      load_beat(2'd0, 64'd7, 1'b0, 1'b0);
      load_beat(2'd0, 64'd5, 1'b1, 1'b0);
      load_beat(2'd1, {$urandom, $urandom}, 1'b1, 1'b1);
      n_cmp++;
      if (bus_if.num_globals !== 9'd3 || bus_if.ready !== 1'b1
          || bus_if.init_ready !== 1'b0) begin
         n_err++;
         $display("FAIL load3: got n=%0d rdy=%b irdy=%b required 3 1 0",
                  bus_if.num_globals, bus_if.ready, bus_if.init_ready);
      end
   endtask

   task automatic test_fwd;
      idle;
      bus_if.wr_en         = 1'b1;
      bus_if.wr_idx        = 8'd1;
      bus_if.wr_data.value = 64'd9;
      bus_if.rd_en         = 2'b01;
      bus_if.rd_idx[0]     = 8'd1;
      tick;
      m_val[1] = 64'd9;
      n_cmp++;
      if (bus_if.wr_done !== 1'b1 || bus_if.rd_valid[0] !== 1'b1) begin
         n_err++;
         $display("FAIL fwd_flags: got done=%b v0=%b required 1 1",
                  bus_if.wr_done, bus_if.rd_valid[0]);
      end
      n_cmp++;
      if (bus_if.rd_data[0].value !== 64'd9
          || bus_if.rd_data[0].vtype !== VT_I32) begin
         n_err++;
         $display("FAIL fwd_data: got %0d required 9",
                  bus_if.rd_data[0].value);
      end
      idle;
      tick;
      n_cmp++;
      if ({bus_if.rd_valid, bus_if.rd_oob, bus_if.wr_done,
           bus_if.wr_error, bus_if.wr_oob} !== '0) begin
         n_err++;
         $display("FAIL pulse_single: got v=%b o=%b d=%b required 0",
                  bus_if.rd_valid, bus_if.rd_oob, bus_if.wr_done);
      end
   endtask

   task automatic test_immutable;
      idle;
      bus_if.wr_en         = 1'b1;
      bus_if.wr_idx        = 8'd0;
      bus_if.wr_data.value = 64'd1;
      tick;
      n_cmp++;
      if (bus_if.wr_error !== 1'b1 || bus_if.wr_done !== 1'b0) begin
         n_err++;
         $display("FAIL immut_flags: got err=%b done=%b required 1 0",
                  bus_if.wr_error, bus_if.wr_done);
      end
      idle;
      bus_if.rd_en     = 2'b10;
      bus_if.rd_idx[1] = 8'd0;
      tick;
      n_cmp++;
      if (bus_if.rd_valid[1] !== 1'b1
          || bus_if.rd_data[1].value !== 64'd7) begin
         n_err++;
         $display("FAIL immut_keep: got v=%b val=%0d required 1 7",
                  bus_if.rd_valid[1], bus_if.rd_data[1].value);
      end
      idle;
   endtask

   task automatic test_oob;
      idle;
      bus_if.rd_en         = 2'b10;
      bus_if.rd_idx[1]     = 8'd3;
      bus_if.wr_en         = 1'b1;
      bus_if.wr_idx        = 8'd200;
      bus_if.wr_data.value = 64'd33;
      tick;
      n_cmp++;
      if (bus_if.rd_oob !== 2'b10 || bus_if.rd_valid !== 2'b00
          || bus_if.rd_data[1] !== '0) begin
         n_err++;
         $display("FAIL rd_oob: got oob=%b v=%b required 10 00",
                  bus_if.rd_oob, bus_if.rd_valid);
      end
      n_cmp++;
      if (bus_if.wr_oob !== 1'b1 || bus_if.wr_done !== 1'b0
          || bus_if.wr_error !== 1'b0) begin
         n_err++;
         $display("FAIL wr_oob: got oob=%b done=%b err=%b required 1 0 0",
                  bus_if.wr_oob, bus_if.wr_done, bus_if.wr_error);
      end
      idle;
   endtask

   task automatic test_random(input int cycles, input int span);
      bit                        we, wok;
      int                        widx;
      logic [63:0]               wval;
      logic [NRD-1:0]            re;
      int                        ridx [NRD];
      logic [2:0]                exp_w;
      logic [NRD-1:0]            exp_v, exp_o;
      stack_entry_t [NRD-1:0]    exp_d;
      for (int c = 0; c < cycles; c++) begin
         we   = 1'($urandom_range(0, 1));
         widx = $urandom_range(0, span - 1);
         wval = {$urandom, $urandom};
         re   = NRD'($urandom);
         if (c % 7 == 0) widx = $urandom_range(0, (m_n < span ? m_n : span) - 1);
         wok   = we && widx < m_n && m_mut[widx];
         exp_w = {wok, we && widx < m_n && !m_mut[widx], we && widx >= m_n};
         exp_v = '0;
         exp_o = '0;
         exp_d = '0;
         for (int p = 0; p < NRD; p++) begin
            ridx[p] = (c % 5 == p) ? widx : $urandom_range(0, span - 1);
            if (re[p] && ridx[p] < m_n) begin
               exp_v[p]       = 1'b1;
               exp_d[p].vtype = val_type_e'(m_vt[ridx[p]]);
               exp_d[p].value = (wok && widx == ridx[p]) ? wval
                                                         : m_val[ridx[p]];
            end else if (re[p]) begin
               exp_o[p] = 1'b1;
            end
         end
         bus_if.wr_en         = we;
         bus_if.wr_idx        = IW'(widx);
         bus_if.wr_data.vtype = val_type_e'($urandom_range(0, 3));
         bus_if.wr_data.value = wval;
         bus_if.rd_en         = re;
         for (int p = 0; p < NRD; p++) bus_if.rd_idx[p] = IW'(ridx[p]);
         tick;
         if (wok) m_val[widx] = wval;
         n_cmp++;
         if ({bus_if.wr_done, bus_if.wr_error, bus_if.wr_oob} !== exp_w) begin
            n_err++;
            $display("FAIL rnd_wr cyc %0d idx %0d: got %b required %b",
                     c, widx, {bus_if.wr_done, bus_if.wr_error,
                     bus_if.wr_oob}, exp_w);
         end
         n_cmp++;
         if (bus_if.rd_valid !== exp_v) begin
            n_err++;
            $display("FAIL rnd_rd_valid cyc %0d: got %b required %b",
                     c, bus_if.rd_valid, exp_v);
         end
         n_cmp++;
         if (bus_if.rd_oob !== exp_o) begin
            n_err++;
            $display("FAIL rnd_rd_oob cyc %0d: got %b required %b",
                     c, bus_if.rd_oob, exp_o);
         end
         n_cmp++;
         if (bus_if.rd_data !== exp_d) begin
            n_err++;
            $display("FAIL rnd_rd_data cyc %0d: got %h required %h",
                     c, bus_if.rd_data, exp_d);
         end
      end
      idle;
   endtask

   task automatic test_full_load;
      int cyc;
      idle;
      bus_if.clear = 1'b1;
      tick;
      idle;
      model_wipe;
      n_cmp++;
      if (bus_if.num_globals !== 9'd0 || bus_if.ready !== 1'b0) begin
         n_err++;
         $display("FAIL clear_run: got n=%0d rdy=%b required 0 0",
                  bus_if.num_globals, bus_if.ready);
      end
      wait_load(1'b1, cyc);
      n_cmp++;
      if (cyc !== 256) begin
         n_err++;
         $display("FAIL clear_sweep_len: got %0d required 256", cyc);
      end
      for (int i = 0; i < NG; i++) begin
         load_beat(2'($urandom), {$urandom, $urandom},
                   (i % 3 != 0), 1'b0);
      end
      n_cmp++;
      if (bus_if.ready !== 1'b1 || bus_if.num_globals !== 9'd256
          || bus_if.init_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_load: got rdy=%b n=%0d irdy=%b required 1 256 0",
                  bus_if.ready, bus_if.num_globals, bus_if.init_ready);
      end
   endtask

   task automatic test_clear_reload;
      int cyc;
      idle;
      bus_if.clear = 1'b1;
      tick;
      idle;
      model_wipe;
      wait_load(1'b0, cyc);
      load_beat(2'd0, 64'd0, 1'b0, 1'b1);
      bus_if.rd_en     = 2'b11;
      bus_if.rd_idx[0] = 8'd0;
      bus_if.rd_idx[1] = 8'd1;
      tick;
      n_cmp++;
      if (bus_if.rd_valid !== 2'b01 || bus_if.rd_oob !== 2'b10
          || bus_if.rd_data !== '0) begin
         n_err++;
         $display("FAIL clear_reload: got v=%b o=%b d=%h required 01 10 0",
                  bus_if.rd_valid, bus_if.rd_oob, bus_if.rd_data);
      end
      idle;
   endtask

   task automatic test_reset_midload;
      int cyc;
      idle;
      bus_if.clear = 1'b1;
      tick;
      idle;
      model_wipe;
      wait_load(1'b0, cyc);
      for (int i = 0; i < 5; i++)
         load_beat(2'd1, {$urandom, $urandom} | 64'd1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus_if.num_globals !== 9'd0 || bus_if.init_ready !== 1'b0
          || bus_if.ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_midload: got n=%0d irdy=%b rdy=%b required 0",
                  bus_if.num_globals, bus_if.init_ready, bus_if.ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_wipe;
      wait_load(1'b0, cyc);
      n_cmp++;
      if (cyc !== 256) begin
         n_err++;
         $display("FAIL rst_sweep_len: got %0d required 256", cyc);
      end
      load_beat(2'd0, 64'd0, 1'b0, 1'b1);
      bus_if.rd_en     = 2'b11;
      bus_if.rd_idx[0] = 8'd0;
      bus_if.rd_idx[1] = 8'd3;
      tick;
      n_cmp++;
      if (bus_if.num_globals !== 9'd1 || bus_if.rd_valid !== 2'b01
          || bus_if.rd_oob !== 2'b10 || bus_if.rd_data !== '0) begin
         n_err++;
         $display("FAIL rst_reload: got n=%0d v=%b o=%b d=%h required 1 01 10 0",
                  bus_if.num_globals, bus_if.rd_valid, bus_if.rd_oob,
                  bus_if.rd_data);
      end
      idle;
   endtask

   initial begin
      test_reset;
      test_load3;
      test_fwd;
      test_immutable;
      test_oob;
      test_random(300, 6);
      test_full_load;
      test_random(400, 256);
      test_clear_reload;
      test_reset_midload;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
